// File: rtl/led_pkg.sv
// led_pkg -- shared definitions for the LED sequencer.
//   mode_e       : pattern selection codes carried on MODE
//   dir_e        : bounce direction
//   presc_width  : prescaler width for a given step divider (min 1 bit)
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // A divider of 1 still needs a one-bit counter so the port exists.
  function automatic int presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// tick_gen -- prescaler that produces one step tick every TICK_DIV enabled cycles.
//   CLK   : clock, rising edge
//   RST   : asynchronous active-high reset, clears the prescaler
//   EN    : 1 = count, 0 = hold
//   tick  : combinational, high on the enabled edge where the count is TICK_DIV-1
//   count : current prescaler value
module tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 6_000_000,
  localparam int CNT_W = presc_width(TICK_DIV)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // With TICK_DIV=1 LAST is 0, so every enabled edge ticks and the
  // counter simply stays at 0.
  always_comb begin
    tick    = EN && (count_q == LAST);
    count_d = count_q;
    if (tick) begin
      count_d = '0;
    end else if (EN) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer -- LED pattern generator with PWM dimming and heartbeat.
//   CLK       : clock, rising edge
//   RST       : asynchronous active-high reset
//   EN        : 1 = advance prescaler/pattern, 0 = freeze them
//   MODE      : 0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count
//   DIM       : PWM duty, 0 = off, all-ones = fully on
//   LED       : registered pattern gated by the PWM duty
//   STEP      : one-cycle registered pulse after every pattern step
//   HEARTBEAT : prescaler bit HB_BIT, freezes along with EN
module led_sequencer
  import led_pkg::*;
#(
  parameter int          NUM_LEDS = 4,
  parameter int unsigned TICK_DIV = 6_000_000,
  parameter int          PWM_BITS = 4,
  parameter int          HB_BIT   = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [1:0]          MODE,
  input  logic [PWM_BITS-1:0] DIM,
  output logic [NUM_LEDS-1:0] LED,
  output logic                STEP,
  output logic                HEARTBEAT
);

  localparam int CNT_W = presc_width(TICK_DIV);
  localparam logic [NUM_LEDS-1:0] ONE     = NUM_LEDS'(1);
  localparam logic [CNT_W-1:0]    HB_MASK = CNT_W'(1) << HB_BIT;

  logic             tick;
  logic [CNT_W-1:0] count;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .tick  (tick),
    .count (count)
  );

  logic [NUM_LEDS-1:0] pattern_q, pattern_d;
  mode_e               mode_q, mode_d;
  dir_e                dir_q, dir_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                step_q, step_d;
  logic                gate;

  // Pattern state machine. The active mode only changes on a step edge;
  // a mode change spends that step reloading the pattern instead of
  // advancing. Bounce reverses when it is already sitting on an end bit,
  // so the end positions are shown once each.
  always_comb begin
    pattern_d = pattern_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    if (tick) begin
      if (mode_e'(MODE) != mode_q) begin
        mode_d    = mode_e'(MODE);
        pattern_d = (mode_e'(MODE) == MODE_COUNT) ? '0 : ONE;
        dir_d     = DIR_UP;
      end else if ((mode_q != MODE_COUNT) && !$onehot(pattern_q)) begin
        pattern_d = ONE;
      end else begin
        case (mode_q)
          MODE_ROT_L:  pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
          MODE_ROT_R:  pattern_d = {pattern_q[0], pattern_q[NUM_LEDS-1:1]};
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pattern_q[NUM_LEDS-1]) begin
                dir_d     = DIR_DOWN;
                pattern_d = pattern_q >> 1;
              end else begin
                pattern_d = pattern_q << 1;
              end
            end else begin
              if (pattern_q[0]) begin
                dir_d     = DIR_UP;
                pattern_d = pattern_q << 1;
              end else begin
                pattern_d = pattern_q >> 1;
              end
            end
          end
          MODE_COUNT:  pattern_d = pattern_q + ONE;
          default:     pattern_d = ONE;
        endcase
      end
    end
  end

  // Free-running PWM and the registered output stage. All-ones DIM forces
  // the gate on so full brightness has no dark slot.
  always_comb begin
    pwm_d  = pwm_q + PWM_BITS'(1);
    gate   = (pwm_q < DIM) || (&DIM);
    led_d  = pattern_q & {NUM_LEDS{gate}};
    step_d = tick;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pattern_q <= ONE;
      mode_q    <= MODE_ROT_L;
      dir_q     <= DIR_UP;
      pwm_q     <= '0;
      led_q     <= '0;
      step_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pwm_q     <= pwm_d;
      led_q     <= led_d;
      step_q    <= step_d;
    end
  end

  assign LED       = led_q;
  assign STEP      = step_q;
  // Masking keeps the whole prescaler value in use while picking one bit.
  assign HEARTBEAT = |(count & HB_MASK);

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer -- directed self-checking bench for led_sequencer
// (NUM_LEDS=4, TICK_DIV=4, PWM_BITS=4, HB_BIT=1). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_led_sequencer;

  localparam int NUM_LEDS = 4;
  localparam int TICK_DIV = 4;
  localparam int PWM_BITS = 4;
  localparam int HB_BIT   = 1;

  logic                CLK;
  logic                RST;
  logic                EN;
  logic [1:0]          MODE;
  logic [PWM_BITS-1:0] DIM;
  logic [NUM_LEDS-1:0] LED;
  logic                STEP;
  logic                HEARTBEAT;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycleCount    = 0;
  int lastStepCycle = 0;

  led_sequencer #(
    .NUM_LEDS (NUM_LEDS),
    .TICK_DIV (TICK_DIV),
    .PWM_BITS (PWM_BITS),
    .HB_BIT   (HB_BIT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .MODE      (MODE),
    .DIM       (DIM),
    .LED       (LED),
    .STEP      (STEP),
    .HEARTBEAT (HEARTBEAT)
  );

  // 10-unit clock with rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Rising-edge counter used to measure the spacing of STEP pulses.
  always @(posedge CLK) cycleCount <= cycleCount + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] mode,
                               input logic [PWM_BITS-1:0] dim);
    EN   = en;
    MODE = mode;
    DIM  = dim;
  endtask

  // Waits (bounded) for the STEP pulse and optionally checks its spacing.
  task automatic waitStep(input string tag, input bit checkPeriod);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge CLK);
      if (STEP) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    else if (checkPeriod) checkOutput({tag, "_period"}, cycleCount - lastStepCycle, TICK_DIV);
    lastStepCycle = cycleCount;
  endtask

  // The new pattern reaches LED one cycle after the STEP pulse appears.
  task automatic stepAndCheck(input string tag, input logic [3:0] expLed,
                              input bit checkPeriod);
    waitStep(tag, checkPeriod);
    @(negedge CLK);
    checkOutput({tag, "_led"}, LED, expLed);
    checkOutput({tag, "_stepLen"}, STEP, 32'd0);
  endtask

  // Right after reset release: step on the TICK_DIV-th enabled edge,
  // heartbeat following prescaler bit 1 (0,1,1,0 for counts 1,2,3,0).
  task automatic checkFirstStep(input string tag, input logic [3:0] expLed);
    logic [3:0] expHb;
    expHb = 4'b0110;
    for (int k = 1; k <= TICK_DIV; k++) begin
      @(negedge CLK);
      checkOutput({tag, "_step"}, STEP, (k == TICK_DIV) ? 32'd1 : 32'd0);
      checkOutput({tag, "_hb"}, HEARTBEAT, expHb[k-1]);
      checkOutput({tag, "_ledHold"}, LED, 32'd1);
    end
    lastStepCycle = cycleCount;
    @(negedge CLK);
    checkOutput({tag, "_led"}, LED, expLed);
  endtask

  task automatic countHighs(input logic [PWM_BITS-1:0] dim, output int highs);
    DIM   = dim;
    highs = 0;
    repeat (16) begin
      @(negedge CLK);
      highs += int'(LED[0]);
    end
  endtask

  initial begin
    logic [3:0] bounceSeq [8];
    int highs;
    bounceSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    RST = 1'b1;
    applyStimulus(1'b0, 2'd0, 4'd15);
    repeat (3) @(negedge CLK);
    checkOutput("rstLed", LED, 32'd0);
    checkOutput("rstStep", STEP, 32'd0);
    checkOutput("rstHb", HEARTBEAT, 32'd0);

    // Rotate-left from reset.
    RST = 1'b0;
    applyStimulus(1'b1, 2'd0, 4'd15);
    checkFirstStep("first", 4'b0010);
    stepAndCheck("rotL", 4'b0100, 1'b1);
    stepAndCheck("rotL", 4'b1000, 1'b1);
    stepAndCheck("rotL", 4'b0001, 1'b1);

    // Bounce: first step reloads, then no repeat at the ends.
    MODE = 2'd2;
    foreach (bounceSeq[i]) stepAndCheck($sformatf("bounce%0d", i), bounceSeq[i], 1'b1);

    // Asynchronous reset between edges, during a STEP pulse.
    waitStep("preRst", 1'b1);
    #2 RST = 1'b1;
    #1;
    checkOutput("asyncRstLed", LED, 32'd0);
    checkOutput("asyncRstStep", STEP, 32'd0);
    checkOutput("asyncRstHb", HEARTBEAT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    checkFirstStep("restart", 4'b0001);
    stepAndCheck("restartBounce", 4'b0010, 1'b1);

    // Binary count with a freeze at 0011.
    MODE = 2'd3;
    stepAndCheck("cntReload", 4'b0000, 1'b1);
    for (int v = 1; v <= 3; v++) stepAndCheck($sformatf("cnt%0d", v), 4'(v), 1'b1);
    @(negedge CLK);
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checkOutput("frzStep", STEP, 32'd0);
      checkOutput("frzHb", HEARTBEAT, 32'd1);
      checkOutput("frzLed", LED, 32'd3);
    end
    EN = 1'b1;
    @(negedge CLK);
    checkOutput("resumeStepEarly", STEP, 32'd0);
    checkOutput("resumeHb", HEARTBEAT, 32'd1);
    @(negedge CLK);
    checkOutput("resumeStep", STEP, 32'd1);
    lastStepCycle = cycleCount;
    @(negedge CLK);
    checkOutput("resumeLed", LED, 32'd4);

    // A MODE glitch between step edges must not disturb the count.
    MODE = 2'd0;
    @(negedge CLK);
    MODE = 2'd3;
    for (int v = 5; v <= 16; v++) stepAndCheck($sformatf("cnt%0d", v), 4'(v % 16), 1'b1);
    for (int v = 1; v <= 6; v++) stepAndCheck($sformatf("cntB%0d", v), 4'(v), 1'b1);

    // Switch to rotate-right at 0110.
    MODE = 2'd1;
    stepAndCheck("rotRReload", 4'b0001, 1'b1);

    // PWM duty with the pattern frozen at 0001.
    EN = 1'b0;
    countHighs(4'd4, highs);
    checkOutput("dim4", highs, 32'd4);
    countHighs(4'd0, highs);
    checkOutput("dim0", highs, 32'd0);
    countHighs(4'd15, highs);
    checkOutput("dim15", highs, 32'd16);

    applyStimulus(1'b1, 2'd1, 4'd15);
    stepAndCheck("rotR", 4'b1000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
